kpn_adder_process: RTL
======================

# kpn_adder_process

KPN process node that consumes one token from each of two input FIFO queues, adds them, and pushes the sum into an output FIFO queue. It sits between the network's queue instances: downstream of two producer queues, upstream of one consumer queue. Blocking-read / blocking-write semantics follow Kahn rules. Tokens are never dropped or duplicated.

## Interface

- BITS_NUMBER, 16, token width; must match the attached queues.
- COUNT_BITS, 16, width of the produced-token counter.

Ports:

- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- empty_a  in  1  input queue A is empty.
- data_a  in  BITS_NUMBER  show-ahead head token of queue A, valid when empty_a=0.
- rd_a  out  1  pop queue A; one pulse per consumed token.
- empty_b  in  1  input queue B is empty.
- data_b  in  BITS_NUMBER  show-ahead head token of queue B.
- rd_b  out  1  pop queue B.
- full_out  in  1  output queue is full.
- data_out  out  BITS_NUMBER  token presented to output queue.
- wr_out  out  1  push data_out into the output queue; one pulse per token.
- token_count  out  COUNT_BITS  number of tokens written since reset, wraps modulo 2^COUNT_BITS.
- busy  out  1  high in any state other than READ_A.

## Operation

- Three-state FSM: READ_A, READ_B, WRITE. Reset state is READ_A.
- READ_A:
  - rd_a = ~empty_a, combinational.
  - On an edge with rd_a=1: reg_a <= data_a, go to READ_B.
  - Otherwise stay in READ_A; blocking read.
- READ_B:
  - rd_b = ~empty_b.
  - On an edge with rd_b=1: sum_reg <= reg_a + data_b, truncated to BITS_NUMBER bits (wrap, carry discarded). Go to WRITE.
  - Otherwise stay.
- WRITE:
  - wr_out = ~full_out; data_out = sum_reg.
  - On an edge with wr_out=1: token_count increments and the FSM goes to READ_A.
  - Otherwise stay; blocking write.
- rd_a, rd_b and wr_out are mutually exclusive; at most one is high in any cycle.
- Reads are strictly ordered, A then B. A token arriving on B while the FSM waits on A is not consumed.
- data_out holds sum_reg in all states; it only changes on the READ_B→WRITE edge.
- Reset (rst_n=0, asynchronous):
  - state=READ_A; reg_a, sum_reg and token_count are 0.
  - rd_a, rd_b and wr_out are forced to 0 while rst_n=0, regardless of the empty/full inputs.
  - data_out=0, busy=0.
- Reset mid-operation discards any partially consumed token. The token already popped from A is lost; this is accepted at network level because all queues reset together.

## Timing

- Pop and capture happen on the same edge. This matches show-ahead queues, which advance their read pointer on the edge where rd=1.
- Minimum throughput: 3 cycles per output token, with both inputs non-empty and the output not full.
- Latency: head of B at READ_B edge → data_out valid on the next cycle. wr_out is high in that same cycle if full_out=0.
- empty/full are sampled combinationally. The flags must be registered queue outputs; no combinational loop through the queue is permitted.
- Count wrap: 0xFFFF + 1 → 0x0000 (COUNT_BITS=16).

## Structure

- Shared package kpn_pkg:
  - KPN_BITS_NUMBER default (16).
  - State enum type kpn_proc_state_t {READ_A, READ_B, WRITE}; reused by later two-input process nodes (subtract, multiply).
- Single module; no sub-module. The adder is one expression and is not split out.
- Integration: queue instances connected to this block must export their empty/full registers as ports.

## Test plan

- Reset:
  - Drive rst_n=0 with empty_a=0 and full_out=0 → rd_a=rd_b=wr_out=0, data_out=0, token_count=0.
  - Release → rd_a=1 in the first cycle.
- Basic add: A=0x0003, B=0x0004, output not full → rd_a edge, then rd_b edge, then wr_out=1 with data_out=0x0007; token_count=1; 3 cycles total.
- Overflow: A=0xFFFF, B=0x0002 → data_out=0x0001, no carry output.
- Blocking:
  - Hold empty_b=1 for 5 cycles after A is consumed → FSM stays in READ_B, rd_b=0, busy=1.
  - Then set full_out=1 for 4 cycles after the B pop → wr_out=0 until full_out drops, then exactly one wr_out pulse.
- Stream: 10 token pairs (A=i, B=2i), i=0..9, with random empty/full stalls → outputs 0,3,6,…,27 in order; token_count=10; no rd pulse while the corresponding empty flag is high.
- Reset mid-operation: assert rst_n=0 in WRITE with sum_reg=0x0009 → asynchronous return to READ_A, data_out=0, no wr_out pulse, token_count=0.

Source files
------------

// File: rtl/kpn_pkg.sv
// Shared definitions for two-input KPN process nodes (adder, subtract, multiply).
package kpn_pkg;

  localparam int KPN_BITS_NUMBER = 16;

  typedef enum logic [1:0] {
    READ_A = 2'd0,
    READ_B = 2'd1,
    WRITE  = 2'd2
  } kpn_proc_state_t;

endpackage

// File: rtl/kpn_adder_process.sv
// KPN adder node: pop A, then pop B, then push A+B; 3 cycles per token minimum, sum visible the cycle after the B pop.
// Blocking reads stall on empty_a/empty_b, blocking write stalls on full_out; nothing is dropped or duplicated.
module kpn_adder_process
  import kpn_pkg::*;
#(
  parameter int BITS_NUMBER = KPN_BITS_NUMBER,
  parameter int COUNT_BITS  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   empty_a,
  input  logic [BITS_NUMBER-1:0] data_a,
  output logic                   rd_a,
  input  logic                   empty_b,
  input  logic [BITS_NUMBER-1:0] data_b,
  output logic                   rd_b,
  input  logic                   full_out,
  output logic [BITS_NUMBER-1:0] data_out,
  output logic                   wr_out,
  output logic [COUNT_BITS-1:0]  token_count,
  output logic                   busy
);

  kpn_proc_state_t        state;
  logic [BITS_NUMBER-1:0] reg_a;
  logic [BITS_NUMBER-1:0] sum_reg;

  // Handshakes are gated by rst_n so no queue moves while reset is held.
  assign rd_a   = rst_n && (state == READ_A) && !empty_a;
  assign rd_b   = rst_n && (state == READ_B) && !empty_b;
  assign wr_out = rst_n && (state == WRITE)  && !full_out;

  assign data_out = sum_reg;
  assign busy     = (state != READ_A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= READ_A;
      reg_a       <= '0;
      sum_reg     <= '0;
      token_count <= '0;
    end else begin
      case (state)
        READ_A: if (rd_a) begin
          reg_a <= data_a;
          state <= READ_B;
        end
        READ_B: if (rd_b) begin
          sum_reg <= reg_a + data_b;
          state   <= WRITE;
        end
        WRITE: if (wr_out) begin
          token_count <= token_count + 1'b1;
          state       <= READ_A;
        end
        default: state <= READ_A;
      endcase
    end
  end

endmodule
